// File: rtl/acpi_pkg.sv
// acpi_pkg: shared CFA encodings, FSM states and fetch-slot constants for the ACPI green interpolator.
package acpi_pkg;

    typedef enum int {PAT_RGGB, PAT_GRBG, PAT_GBRG, PAT_BGGR} pattern_t;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CALC, S_WRITE, S_DONE} state_t;

    localparam logic [3:0] SLOT_C  = 4'd0;
    localparam logic [3:0] SLOT_L2 = 4'd1;
    localparam logic [3:0] SLOT_L1 = 4'd2;
    localparam logic [3:0] SLOT_R1 = 4'd3;
    localparam logic [3:0] SLOT_R2 = 4'd4;
    localparam logic [3:0] SLOT_U2 = 4'd5;
    localparam logic [3:0] SLOT_U1 = 4'd6;
    localparam logic [3:0] SLOT_D1 = 4'd7;
    localparam logic [3:0] SLOT_D2 = 4'd8;

    // Parity of (row^col) that marks a green site.
    function automatic logic green_parity(int pattern);
        return pattern == PAT_RGGB || pattern == PAT_BGGR;
    endfunction

    function automatic int slot_off(logic [3:0] slot, int w);
        case (slot)
            SLOT_L2: return -2;
            SLOT_L1: return -1;
            SLOT_R1: return 1;
            SLOT_R2: return 2;
            SLOT_U2: return -2 * w;
            SLOT_U1: return -w;
            SLOT_D1: return w;
            SLOT_D2: return 2 * w;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/acpi_green_core.sv
// acpi_green_core: combinational gradient-selected ACPI green estimate from a 9-pixel cross, clamped.
module acpi_green_core
    import acpi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [9*DATA_WIDTH-1:0] slots_i,
    output logic [DATA_WIDTH-1:0]   g_o
);

    localparam int W = DATA_WIDTH + 3;
    typedef logic signed [W-1:0] sw_t;

    function automatic sw_t abs_s(sw_t x);
        return x < 0 ? -x : x;
    endfunction

    sw_t v [9];
    sw_t lh, lv, dh, dv, gh, gv, g;

    always_comb begin
        for (int i = 0; i < 9; i++) v[i] = $signed({3'b000, slots_i[i*DATA_WIDTH +: DATA_WIDTH]});
        lh = v[SLOT_C] + v[SLOT_C] - v[SLOT_L2] - v[SLOT_R2];
        lv = v[SLOT_C] + v[SLOT_C] - v[SLOT_U2] - v[SLOT_D2];
        dh = abs_s(v[SLOT_L1] - v[SLOT_R1]) + abs_s(lh);
        dv = abs_s(v[SLOT_U1] - v[SLOT_D1]) + abs_s(lv);
        gh = ((v[SLOT_L1] + v[SLOT_R1]) >>> 1) + (lh >>> 2);
        gv = ((v[SLOT_U1] + v[SLOT_D1]) >>> 1) + (lv >>> 2);
        g  = dh < dv ? gh : dv < dh ? gv : (gh + gv) >>> 1;
        g_o = g < 0 ? '0 : g > sw_t'((1 << DATA_WIDTH) - 1) ? '1 : g[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/acpi_green_interp.sv
// acpi_green_interp: scans a Bayer frame, fetches a 9-pixel cross at interior R/B sites
// and writes the ACPI green estimate; all other pixels are written through.
module acpi_green_interp
    import acpi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int ADDRESS    = $clog2(IMG_W*IMG_H),
    parameter int PATTERN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDRESS-1:0]    bayer_addr,
    output logic                  bayer_req,
    input  logic                  bayer_ready,
    input  logic [DATA_WIDTH-1:0] bayer_data,
    output logic [ADDRESS-1:0]    acpi_addr,
    output logic                  acpi_valid,
    output logic [DATA_WIDTH-1:0] acpi_data,
    output logic                  finish
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] R_LO = RW'(2);
    localparam logic [RW-1:0] R_HI = RW'(IMG_H - 3);
    localparam logic [CW-1:0] C_LO = CW'(2);
    localparam logic [CW-1:0] C_HI = CW'(IMG_W - 3);
    localparam logic [CW-1:0] C_END = CW'(IMG_W - 1);
    localparam logic [ADDRESS-1:0] P_END = ADDRESS'(IMG_W*IMG_H - 1);
    localparam logic GP = green_parity(PATTERN);

    state_t                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [ADDRESS-1:0]      pix_q, pix_d;
    logic [3:0]              idx_q, idx_d;
    logic                    acc_q;
    logic [3:0]              acc_slot_q;
    logic [DATA_WIDTH-1:0]   slot_q [9];
    logic [ADDRESS-1:0]      acpi_addr_q, acpi_addr_d;
    logic                    acpi_valid_q, acpi_valid_d;
    logic [DATA_WIDTH-1:0]   acpi_data_q, acpi_data_d;
    logic [9*DATA_WIDTH-1:0] slots;
    logic [DATA_WIDTH-1:0]   core_g;
    logic                    full, accept;
    logic [3:0]              last_idx;

    assign full = row_q >= R_LO && row_q <= R_HI && col_q >= C_LO && col_q <= C_HI
                  && ((row_q[0] ^ col_q[0]) != GP);
    assign last_idx   = full ? SLOT_D2 : SLOT_C;
    assign bayer_req  = state_q == S_ISSUE;
    assign accept     = bayer_req && bayer_ready;
    // Address tracks idx_q, so it holds steady while a request waits for ready.
    assign bayer_addr = ADDRESS'(int'(pix_q) + slot_off(idx_q, IMG_W));
    assign acpi_addr  = acpi_addr_q;
    assign acpi_valid = acpi_valid_q;
    assign acpi_data  = acpi_data_q;
    assign finish     = state_q == S_DONE;

    always_comb begin
        slots = '0;
        for (int i = 0; i < 9; i++) slots[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
    end

    acpi_green_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .slots_i(slots),
        .g_o    (core_g)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_d        = pix_q;
        idx_d        = idx_q;
        acpi_valid_d = 1'b0;
        acpi_addr_d  = acpi_addr_q;
        acpi_data_d  = acpi_data_q;
        case (state_q)
            S_IDLE:  state_d = S_ISSUE;
            S_ISSUE: if (accept) begin
                idx_d   = idx_q == last_idx ? SLOT_C : idx_q + 4'd1;
                state_d = idx_q == last_idx ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: state_d = S_CALC;
            S_CALC: begin
                state_d      = S_WRITE;
                acpi_valid_d = 1'b1;
                acpi_addr_d  = pix_q;
                acpi_data_d  = full ? core_g : slot_q[SLOT_C];
            end
            S_WRITE: if (pix_q == P_END) state_d = S_DONE;
            else begin
                state_d = S_ISSUE;
                pix_d   = pix_q + ADDRESS'(1);
                col_d   = col_q == C_END ? '0 : col_q + CW'(1);
                row_d   = col_q == C_END ? row_q + RW'(1) : row_q;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            pix_q        <= '0;
            idx_q        <= SLOT_C;
            acc_q        <= 1'b0;
            acc_slot_q   <= SLOT_C;
            acpi_addr_q  <= '0;
            acpi_valid_q <= 1'b0;
            acpi_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_q        <= pix_d;
            idx_q        <= idx_d;
            acc_q        <= accept;
            acc_slot_q   <= idx_q;
            acpi_addr_q  <= acpi_addr_d;
            acpi_valid_q <= acpi_valid_d;
            acpi_data_q  <= acpi_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_q) slot_q[acc_slot_q] <= bayer_data;
    end

endmodule

// File: tb/tb_acpi_green_interp.sv
// tb_acpi_green_interp: four configurations (size/pattern) run side by side against an arithmetic reference.
module tb_acpi_green_interp;

    localparam int NI = 4;

    function automatic int cfg_w(int g);
        return (g == 1 || g == 3) ? 12 : 8;
    endfunction

    function automatic int cfg_h(int g);
        return (g == 1 || g == 3) ? 6 : 8;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] b_addr [NI];
    logic       b_req  [NI];
    logic       rdy    [NI];
    logic [7:0] b_data [NI];
    logic [6:0] a_addr [NI];
    logic       a_valid[NI];
    logic [7:0] a_data [NI];
    logic       fin    [NI];
    logic [7:0] mem    [NI][128];
    logic [7:0] obs    [NI][128];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        acpi_green_interp #(
            .DATA_WIDTH(8), .IMG_W(cfg_w(g)), .IMG_H(cfg_h(g)), .ADDRESS(7), .PATTERN(g)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .bayer_addr (b_addr[g]),
            .bayer_req  (b_req[g]),
            .bayer_ready(rdy[g]),
            .bayer_data (b_data[g]),
            .acpi_addr  (a_addr[g]),
            .acpi_valid (a_valid[g]),
            .acpi_data  (a_data[g]),
            .finish     (fin[g])
        );
    end

    // Memory answers the address presented in the previous cycle, i.e. the accepted one.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NI; g++) b_data[g] <= mem[g][b_addr[g]];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(int x);
        return x < 0 ? -x : x;
    endfunction

    function automatic bit is_full(int g, int a);
        int w = cfg_w(g), h = cfg_h(g), r = a / cfg_w(g), c = a % cfg_w(g);
        int gp = (g == 0 || g == 3) ? 1 : 0;
        return ((r ^ c) & 1) != gp && r >= 2 && r <= h - 3 && c >= 2 && c <= w - 3;
    endfunction

    function automatic int model(int g, int a);
        int w = cfg_w(g);
        int cc, l2, l1, r1, r2, u2, u1, d1, d2, lh, lv, dh, dv, gh, gv, gg;
        if (!is_full(g, a)) return int'(mem[g][a]);
        cc = mem[g][a];     l2 = mem[g][a-2];   l1 = mem[g][a-1];
        r1 = mem[g][a+1];   r2 = mem[g][a+2];
        u2 = mem[g][a-2*w]; u1 = mem[g][a-w];   d1 = mem[g][a+w]; d2 = mem[g][a+2*w];
        lh = 2*cc - l2 - r2;
        lv = 2*cc - u2 - d2;
        dh = iabs(l1 - r1) + iabs(lh);
        dv = iabs(u1 - d1) + iabs(lv);
        gh = ((l1 + r1) >>> 1) + (lh >>> 2);
        gv = ((u1 + d1) >>> 1) + (lv >>> 2);
        gg = dh < dv ? gh : dv < dh ? gv : (gh + gv) >>> 1;
        return gg < 0 ? 0 : gg > 255 ? 255 : gg;
    endfunction

    function automatic int exp_cycles(int g);
        int n = 0;
        for (int a = 0; a < cfg_w(g) * cfg_h(g); a++) n += is_full(g, a) ? 1 : 0;
        return 1 + 4 * cfg_w(g) * cfg_h(g) + 8 * n;
    endfunction

    task automatic chk_rst(input int g);
        chk($sformatf("rst_vals[%0d]", g),
            int'({b_addr[g], b_req[g], a_addr[g], a_valid[g], a_data[g], fin[g]}), 0);
    endtask

    task automatic run_frame(input bit stall, input int abort_at);
        int         wcnt[NI], fin_at[NI], cyc;
        logic [6:0] paddr[NI];
        logic       preq[NI], prdy[NI];
        bit         done;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk_rst(g);
            wcnt[g] = 0; fin_at[g] = -1; preq[g] = 1'b0; prdy[g] = 1'b1; paddr[g] = '0; rdy[g] = 1'b1;
        end
        rst = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            done = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (preq[g] && !prdy[g]) begin
                    chk($sformatf("hold_req[%0d]", g), int'(b_req[g]), 1);
                    chk($sformatf("hold_addr[%0d]", g), int'(b_addr[g]), int'(paddr[g]));
                end
                if (a_valid[g]) begin
                    chk($sformatf("wr_addr[%0d]", g), int'(a_addr[g]), wcnt[g]);
                    chk($sformatf("wr_data[%0d]@%0d", g, wcnt[g]), int'(a_data[g]), model(g, wcnt[g]));
                    obs[g][a_addr[g]] = a_data[g];
                    wcnt[g]++;
                end
                if (fin_at[g] >= 0) chk($sformatf("fin_sticky[%0d]", g), int'(fin[g]), 1);
                else if (fin[g]) begin
                    fin_at[g] = cyc;
                    chk($sformatf("fin_writes[%0d]", g), wcnt[g], cfg_w(g) * cfg_h(g));
                    if (!stall) chk($sformatf("frame_cycles[%0d]", g), cyc, exp_cycles(g));
                end
                if (fin_at[g] < 0) done = 1'b0;
                rdy[g]   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                preq[g]  = b_req[g];
                paddr[g] = b_addr[g];
                prdy[g]  = rdy[g];
            end
            if (abort_at >= 0 && wcnt[0] == abort_at && b_req[0]) begin
                rst = 1'b1;
                #1;
                chk_rst(0);
                return;
            end
            if (abort_at >= 0 && fin_at[0] >= 0) begin
                chk("abort_reached", 0, 1);
                return;
            end
            if (done) break;
            if (cyc > 20000) begin
                chk("timeout", 0, 1);
                break;
            end
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("fin_hold[%0d]", g), int'(fin[g]), 1);
    endtask

    task automatic fill(input int kind);
        for (int g = 0; g < NI; g++)
            for (int a = 0; a < 128; a++)
                mem[g][a] = kind == 0 ? 8'd100 : kind == 1 ? 8'((a * 7 + g * 13) & 255) : 8'($urandom);
    endtask

    task automatic set_cross(input int a, input int c, input int l2, input int l1, input int r1,
                             input int r2, input int u2, input int u1, input int d1, input int d2);
        mem[0][a]    = 8'(c);
        mem[0][a-2]  = 8'(l2); mem[0][a-1] = 8'(l1); mem[0][a+1] = 8'(r1); mem[0][a+2] = 8'(r2);
        mem[0][a-16] = 8'(u2); mem[0][a-8] = 8'(u1); mem[0][a+8] = 8'(d1); mem[0][a+16] = 8'(d2);
    endtask

    task automatic directed(input bit stall, input bit low);
        fill(2);
        for (int a = 0; a < 128; a++) mem[0][a] = 8'd0;
        set_cross(18, 50, 50, 10, 30, 50, 50, 80, 80, 50);
        if (low) set_cross(45, 0, 255, 10, 10, 255, 255, 10, 10, 255);
        else     set_cross(45, 255, 0, 250, 250, 0, 0, 250, 250, 0);
        run_frame(stall, -1);
        chk("vert_pref", int'(obs[0][18]), 80);
        chk(low ? "clamp_lo" : "clamp_hi", int'(obs[0][45]), low ? 0 : 255);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) rdy[g] = 1'b1;
        fill(0);
        run_frame(1'b0, -1);
        for (int g = 0; g < NI; g++) chk($sformatf("flat_last[%0d]", g), int'(obs[g][cfg_w(g)*cfg_h(g)-1]), 100);
        directed(1'b0, 1'b0);
        directed(1'b0, 1'b1);
        fill(0);
        run_frame(1'b1, -1);
        directed(1'b1, 1'b0);
        fill(1);
        run_frame(1'b0, -1);
        fill(2);
        run_frame(1'b1, -1);
        fill(2);
        run_frame(1'b0, 20);
        run_frame(1'b0, -1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
